// File: rtl/shift_sequencer_pkg.sv
// Shared CPU definitions for the ALU shift path: op codes, FSM states and widths.
package shift_sequencer_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SHAMT_W = 4;

  // Also used by the result-mux select decoding.
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shifter: logical left (zero fill) or arithmetic right (sign fill).
module shift_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_is_sra,
  output logic [WIDTH-1:0] o_value
);

  always_comb begin
    if (i_is_sra) begin
      o_value = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
    end else begin
      o_value = {i_value[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: one bit per clock, with a uniform start/done
// handshake that also carries non-shift ALU results through in one cycle.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned AMT_W = SHAMT_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       ALUOp,
  input  logic [WIDTH-1:0] Operand,
  input  logic [AMT_W-1:0] Amount,
  input  logic [WIDTH-1:0] ALUResult,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Dalja,
  output logic [2:0]       Sel
);

  state_e           r_state;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dalja;
  logic [2:0]       r_sel;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_shifted;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .i_value  (r_work),
    .i_is_sra (r_sel == OP_SRA),
    .o_value  (w_shifted)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_dalja <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_sel  <= ALUOp;
            r_busy <= 1'b1;
            if (is_shift_op(ALUOp) && (Amount != '0)) begin
              r_work  <= Operand;
              r_cnt   <= Amount;
              r_state <= SHIFT;
            end else begin
              // Zero-amount shifts and non-shift ops finish immediately.
              r_dalja <= is_shift_op(ALUOp) ? Operand : ALUResult;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        SHIFT: begin
          r_work <= w_shifted;
          r_cnt  <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_dalja <= w_shifted;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Busy  = r_busy;
  assign Stall = r_busy;
  assign Done  = r_done;
  assign Dalja = r_dalja;
  assign Sel   = r_sel;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a latency/result model.
module tb_shift_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  ALUOp = '0;
  logic [15:0] Operand = '0;
  logic [3:0]  Amount = '0;
  logic [15:0] ALUResult = '0;
  logic        Busy, Stall, Done;
  logic [15:0] Dalja;
  logic [2:0]  Sel;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer #(
    .WIDTH (16),
    .AMT_W (4)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .ALUOp     (ALUOp),
    .Operand   (Operand),
    .Amount    (Amount),
    .ALUResult (ALUResult),
    .Busy      (Busy),
    .Stall     (Stall),
    .Done      (Done),
    .Dalja     (Dalja),
    .Sel       (Sel)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted request keeps the core busy for `lat` cycles, the
  // last of which is Done; the result appears when Done rises.
  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [15:0] opnd,
                                             input logic [3:0] amt, input logic [15:0] alu);
    logic signed [15:0] s;
    s = opnd;
    if (op == 3'b110) return opnd << amt;
    if (op == 3'b111) return 16'(s >>> amt);
    return alu;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [3:0] amt);
    if ((op == 3'b110 || op == 3'b111) && amt != 0) return int'(amt) + 1;
    return 1;
  endfunction

  int          m_rem = 0;
  logic [15:0] m_dalja = '0, m_pend = '0;
  logic [2:0]  m_sel = '0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_rem = 0; m_dalja = '0; m_sel = '0;
    end else if (m_rem == 0) begin
      if (Start) begin
        m_sel  = ALUOp;
        m_pend = ref_result(ALUOp, Operand, Amount, ALUResult);
        m_rem  = ref_latency(ALUOp, Amount);
        if (m_rem == 1) m_dalja = m_pend;
      end
    end else begin
      m_rem--;
      if (m_rem == 1) m_dalja = m_pend;
    end
    #1;
    chk("model_busy",  32'(Busy),  32'(m_rem > 0));
    chk("model_stall", 32'(Stall), 32'(m_rem > 0));
    chk("model_done",  32'(Done),  32'(m_rem == 1));
    chk("model_dalja", 32'(Dalja), 32'(m_dalja));
    chk("model_sel",   32'(Sel),   32'(m_sel));
  end

  // Issue one request and measure the cycles until Done, with a bounded wait.
  task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] opnd,
                        input logic [3:0] amt, input logic [15:0] alu,
                        input int exp_lat, input logic [15:0] exp_dalja);
    int lat;
    int busy_cycles;
    lat = -1;
    busy_cycles = 0;
    @(negedge Clock);
    Start = 1'b1; ALUOp = op; Operand = opnd; Amount = amt; ALUResult = alu;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      if (k == 1) begin
        Start = 1'b0; Operand = ~opnd; Amount = ~amt; ALUResult = ~alu;
      end
      if (Busy) busy_cycles++;
      if (Done) begin
        lat = k;
        break;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
    chk({name, "_dalja"}, 32'(Dalja), 32'(exp_dalja));
    chk({name, "_sel"}, 32'(Sel), 32'(op));
  endtask

  initial begin
    int dones;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_dalja", 32'(Dalja), 32'h0000);
    chk("reset_sel", 32'(Sel), 32'd0);

    run_op("sll1x4", 3'b110, 16'h0001, 4'd4, 16'h0000, 5, 16'h0010);
    run_op("sra8000x15", 3'b111, 16'h8000, 4'd15, 16'h0000, 16, 16'hFFFF);
    run_op("sra4000x14", 3'b111, 16'h4000, 4'd14, 16'h0000, 15, 16'h0001);
    run_op("sllx15", 3'b110, 16'h8001, 4'd15, 16'h0000, 16, 16'h8000);
    run_op("sllx0", 3'b110, 16'hABCD, 4'd0, 16'h5555, 1, 16'hABCD);
    run_op("nonshift", 3'b000, 16'h9999, 4'd5, 16'h1234, 1, 16'h1234);

    // Second Start during SHIFT must be ignored.
    @(negedge Clock);
    Start = 1'b1; ALUOp = 3'b110; Operand = 16'h0003; Amount = 4'd8;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Start = 1'b1; ALUOp = 3'b111; Operand = 16'hF0F0; Amount = 4'd2;
    @(negedge Clock);
    Start = 1'b0;
    dones = 0;
    for (int k = 0; k < 14; k++) begin
      if (Done) begin
        dones++;
        chk("ignored_start_dalja", 32'(Dalja), 32'h0300);
        chk("ignored_start_sel", 32'(Sel), 32'b110);
      end
      @(negedge Clock);
    end
    chk("ignored_start_done_count", 32'(dones), 32'd1);

    // Reset on the third SHIFT cycle aborts without Done.
    Start = 1'b1; ALUOp = 3'b111; Operand = 16'hF000; Amount = 4'd10;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_dalja", 32'(Dalja), 32'h0000);
    chk("abort_sel", 32'(Sel), 32'd0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clock);
      if (Done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_op("after_abort", 3'b110, 16'h0001, 4'd1, 16'h0000, 2, 16'h0002);

    // Reset wins over a simultaneous Start.
    @(negedge Clock);
    Reset = 1'b1; Start = 1'b1; ALUOp = 3'b110; Operand = 16'h00FF; Amount = 4'd3;
    @(negedge Clock);
    Reset = 1'b0; Start = 1'b0;
    chk("reset_start_busy", 32'(Busy), 32'd0);
    chk("reset_start_sel", 32'(Sel), 32'd0);
    @(negedge Clock);
    chk("reset_start_busy_later", 32'(Busy), 32'd0);

    // Randomized traffic, checked cycle by cycle by the model.
    for (int k = 0; k < 3000; k++) begin
      Start = ($urandom_range(0, 2) != 0);
      ALUOp = ($urandom_range(0, 1) != 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      Operand = 16'($urandom);
      Amount = 4'($urandom);
      ALUResult = 16'($urandom);
      Reset = ($urandom_range(0, 99) == 0);
      @(negedge Clock);
    end
    Reset = 1'b0; Start = 1'b0;
    repeat (2) @(negedge Clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller for the ALU shift path of the 16-bit CPU. It accepts a shift request with an operand, a 4-bit amount and the 3-bit ALU operation code. It shifts one bit per clock, stalls the core while busy, and presents the final result together with the latched select code for the ALU result mux. Non-shift operations pass the combinational ALU result through in one cycle, so the core sees a uniform start/done handshake.

## Interface
- `WIDTH`, 16: datapath width.
- `AMT_W`, 4: shift-amount width; maximum shift is 2^AMT_W − 1.

- `Clock`  in  1  — single clock; all state updates on its rising edge.
- `Reset`  in  1  — synchronous, active-high.
- `Start`  in  1  — request strobe; sampled only in IDLE.
- `ALUOp`  in  3  — operation code: 110 = SLL, 111 = SRA, any other value = non-shift.
- `Operand`  in  WIDTH  — value to shift; sampled with `Start`.
- `Amount`  in  AMT_W  — shift count; sampled with `Start`.
- `ALUResult`  in  WIDTH  — combinational result of the non-shift ALU ops; sampled with `Start`.
- `Busy`  out  1  — high in SHIFT and DONE.
- `Stall`  out  1  — equal to `Busy`; holds the core's PC and pipeline register.
- `Done`  out  1  — one-cycle pulse marking a valid `Dalja`.
- `Dalja`  out  WIDTH  — result register; holds its value until the next accepted `Start`.
- `Sel`  out  3  — latched `ALUOp`, driven to the result mux.

## Operation
- States:
  - IDLE: `Busy`/`Stall`/`Done` low.
  - SHIFT: `Busy` high.
  - DONE: `Busy` and `Done` high for exactly one cycle; always returns to IDLE next.
- IDLE with `Start` = 1:
  - Latch `ALUOp` into `Sel`.
  - Shift op with `Amount` ≠ 0:
    - Load `Operand` into the work register and `Amount` into the down-counter.
    - Go to SHIFT.
  - Shift op with `Amount` = 0: load `Operand` into `Dalja`; go to DONE.
  - Non-shift op: load `ALUResult` into `Dalja`; go to DONE.
- SHIFT, once per cycle:
  - SLL: work register shifts left by 1, zero-filled.
  - SRA: work register shifts right by 1, bit WIDTH−1 replicated.
  - The counter decrements each cycle.
  - When the counter is 1 before decrement, the shifted value is written to `Dalja` and the state goes to DONE.
- `Dalja` is written only on the transition into DONE; it is stable during SHIFT (it holds the previous result).
- `Start` is ignored outside IDLE; there is no queueing.
- `Operand`, `Amount` and `ALUResult` may change freely after the sampling cycle.

## Timing
- Reset values: state IDLE, `Dalja` = 0x0000, `Sel` = 000, counter 0, work register 0, `Busy` = `Stall` = `Done` = 0.
- Latency is measured from the edge that samples `Start`:
  - Shift op, amount N ≥ 1: `Done` is high in the cycle after N SHIFT cycles, i.e. N+1 cycles after the `Start` edge.
  - Amount 0 or non-shift op: `Done` is high in the cycle immediately after the `Start` edge (latency 1).
- Back-to-back: the earliest next accepted `Start` is in the IDLE cycle following DONE. Throughput is one op per N+2 cycles for shifts.
- `Reset` mid-operation: on the next edge, the state goes to IDLE and all registers take their reset values. No `Done` pulse is issued for the aborted op.
- `Reset` and `Start` in the same cycle: `Reset` wins; the request is dropped.
- Maximum amount 15 on SRA of a negative operand yields all ones; SLL by 15 keeps only bit 0 of the operand, moved to bit 15.

## Structure
- Shared CPU package holds:
  - Op constants `OP_SLL = 3'b110`, `OP_SRA = 3'b111`.
  - State enum {IDLE, SHIFT, DONE}.
  - Width constants.
  - The same op constants are used by the result-mux select decoding.
- One natural sub-module, `shift_step`: combinational single-bit shifter with inputs (value, is_sra) and output (shifted value). The FSM, counter and registers stay in `shift_sequencer`.

## Test plan
- Reset, then `Start`, SLL, `Operand` = 0x0001, `Amount` = 4 → `Busy` high for 5 cycles; `Done` pulses 5 cycles after `Start`; `Dalja` = 0x0010; `Sel` = 110.
- SRA, 0x8000, amount 15 → `Done` 16 cycles after `Start`; `Dalja` = 0xFFFF. SRA, 0x4000, amount 14 → `Dalja` = 0x0001.
- SLL, 0xABCD, amount 0 → `Done` 1 cycle after `Start`; `Dalja` = 0xABCD. Non-shift `ALUOp` = 000 with `ALUResult` = 0x1234 → `Done` next cycle; `Dalja` = 0x1234; `Sel` = 000.
- SLL, 0x0003, amount 8; pulse `Start` again with different inputs during SHIFT → second request ignored; `Dalja` = 0x0300; a single `Done` pulse.
- SRA, 0xF000, amount 10; assert `Reset` on the 3rd SHIFT cycle → next cycle state IDLE, all outputs 0; no `Done`. A fresh SLL, 0x0001, amount 1 then completes with `Dalja` = 0x0002.
- `Reset` high together with `Start` → no state change from IDLE; `Busy` stays 0.
